// File: rtl/fewcore_pkg.sv
// Shared types for the fewcore pipeline: default widths, issue queue entry
// layout and the writeback operand-forwarding helper.
package fewcore_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int PCLEN_DEF = 10;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [PCLEN_DEF-1:0] pc;
    logic [4:0]           rd;
    logic [4:0]           rs1_idx;
    logic [4:0]           rs2_idx;
    logic [XLEN_DEF-1:0]  rs1;
    logic [XLEN_DEF-1:0]  rs2;
    logic [XLEN_DEF-1:0]  imm;
    logic [11:0]          code;
    logic                 is_load;
    logic                 is_branch;
  } issue_entry_t;

  // wb_en already excludes x0, so a match here never patches register 0
  function automatic logic [XLEN_DEF-1:0] patch_operand(
    input logic [4:0]          idx,
    input logic [XLEN_DEF-1:0] val,
    input logic                wb_en,
    input logic [4:0]          wb_rd,
    input logic [XLEN_DEF-1:0] wb_data
  );
    if (wb_en && (idx == wb_rd)) begin
      return wb_data;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/busy_table.sv
// Register scoreboard: one pending-write bit per architectural register,
// set on issue, cleared on writeback, set wins on a same-cycle collision.
module busy_table
  import fewcore_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  input  logic [4:0]  rd_idx,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy,
  output logic [31:0] busy_vec
);

  logic [31:0] busy_r;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;
  logic [31:0] busy_nxt_s;

  assign set_mask_s = set_en ? (32'd1 << set_idx) : 32'd0;
  assign clr_mask_s = clr_en ? (32'd1 << clr_idx) : 32'd0;
  assign busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;

  // Scoreboard state; bit 0 is forced clear so x0 never stalls issue
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign rs1_busy = busy_r[rs1_idx];
  assign rs2_busy = busy_r[rs2_idx];
  assign rd_busy  = busy_r[rd_idx];
  assign busy_vec = busy_r;

endmodule

// File: rtl/issue_stage.sv
// In-order issue queue between fetch and execute: holds decoded instructions,
// forwards writeback values into queued operands and issues the head when hazard-free.
module issue_stage
  import fewcore_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int PCLEN = PCLEN_DEF,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [PCLEN-1:0] inPc,
  input  logic [4:0]       inRd,
  input  logic [4:0]       inRs1Idx,
  input  logic [4:0]       inRs2Idx,
  input  logic [XLEN-1:0]  inRs1,
  input  logic [XLEN-1:0]  inRs2,
  input  logic [XLEN-1:0]  inImm,
  input  logic [11:0]      inCode,
  input  logic             inIsLoad,
  input  logic             inIsBranch,
  input  logic             wbValid,
  input  logic [4:0]       wbRd,
  input  logic [XLEN-1:0]  wbData,
  input  logic             brDone,
  input  logic             flush,
  output logic             outValid,
  input  logic             outReady,
  output logic [PCLEN-1:0] outPc,
  output logic [4:0]       outRd,
  output logic [XLEN-1:0]  outRs1,
  output logic [XLEN-1:0]  outRs2,
  output logic [XLEN-1:0]  outImm,
  output logic [11:0]      outCode,
  output logic             outIsLoad,
  output logic             outIsBranch,
  output logic [31:0]      busyVec
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  issue_entry_t     q_r [DEPTH];
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic             branch_pending_r;

  issue_entry_t     head_s;
  issue_entry_t     in_entry_s;
  logic             wb_hit_s;
  logic             enq_s;
  logic             xfer_s;
  logic             rs1_busy_s;
  logic             rs2_busy_s;
  logic             rd_busy_s;

  assign head_s   = q_r[head_r];
  assign wb_hit_s = wbValid && (wbRd != REG_ZERO);
  assign inReady  = (count_r < CW'(DEPTH)) && !flush;
  assign enq_s    = inValid && inReady;
  assign outValid = (count_r != {CW{1'b0}}) && !branch_pending_r && !rs1_busy_s
                    && !rs2_busy_s && !rd_busy_s && !flush;
  assign xfer_s   = outValid && outReady;

  // Incoming instruction, with a same-cycle writeback captured over the fetch-time operands
  always_comb begin
    in_entry_s           = '0;
    in_entry_s.pc        = inPc;
    in_entry_s.rd        = inRd;
    in_entry_s.rs1_idx   = inRs1Idx;
    in_entry_s.rs2_idx   = inRs2Idx;
    in_entry_s.rs1       = patch_operand(inRs1Idx, inRs1, wb_hit_s, wbRd, wbData);
    in_entry_s.rs2       = patch_operand(inRs2Idx, inRs2, wb_hit_s, wbRd, wbData);
    in_entry_s.imm       = inImm;
    in_entry_s.code      = inCode;
    in_entry_s.is_load   = inIsLoad;
    in_entry_s.is_branch = inIsBranch;
  end

  busy_table u_busy (
    .clk      (clk),
    .reset    (reset),
    .set_en   (xfer_s && (head_s.rd != REG_ZERO)),
    .set_idx  (head_s.rd),
    .clr_en   (wb_hit_s),
    .clr_idx  (wbRd),
    .rs1_idx  (head_s.rs1_idx),
    .rs2_idx  (head_s.rs2_idx),
    .rd_idx   (head_s.rd),
    .rs1_busy (rs1_busy_s),
    .rs2_busy (rs2_busy_s),
    .rd_busy  (rd_busy_s),
    .busy_vec (busyVec)
  );

  // Queue storage, pointers and branch gate; patching free slots is harmless since enqueue overwrites them
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i] <= '0;
      end
      head_r           <= '0;
      tail_r           <= '0;
      count_r          <= '0;
      branch_pending_r <= 1'b0;
    end else if (flush) begin
      head_r           <= '0;
      tail_r           <= '0;
      count_r          <= '0;
      branch_pending_r <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i].rs1 <= patch_operand(q_r[i].rs1_idx, q_r[i].rs1, wb_hit_s, wbRd, wbData);
        q_r[i].rs2 <= patch_operand(q_r[i].rs2_idx, q_r[i].rs2, wb_hit_s, wbRd, wbData);
      end
      if (enq_s) begin
        q_r[tail_r] <= in_entry_s;
        tail_r      <= tail_r + PW'(1);
      end else begin
        tail_r      <= tail_r;
      end
      if (xfer_s) begin
        head_r <= head_r + PW'(1);
      end else begin
        head_r <= head_r;
      end
      count_r <= count_r + CW'(enq_s) - CW'(xfer_s);
      if (xfer_s && head_s.is_branch) begin
        branch_pending_r <= 1'b1;
      end else if (brDone) begin
        branch_pending_r <= 1'b0;
      end else begin
        branch_pending_r <= branch_pending_r;
      end
    end
  end

  assign outPc       = head_s.pc;
  assign outRd       = head_s.rd;
  assign outRs1      = head_s.rs1;
  assign outRs2      = head_s.rs2;
  assign outImm      = head_s.imm;
  assign outCode     = head_s.code;
  assign outIsLoad   = head_s.is_load;
  assign outIsBranch = head_s.is_branch;

endmodule

// File: tb/tb_issue_stage.sv
// Randomized bench for issue_stage against a queue-based reference model,
// preceded by a directed reset and read-after-write sequence.
module tb_issue_stage;
  import fewcore_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, inValid, inReady, inIsLoad, inIsBranch;
  logic [9:0]  inPc;
  logic [4:0]  inRd, inRs1Idx, inRs2Idx, wbRd;
  logic [31:0] inRs1, inRs2, inImm, wbData;
  logic [11:0] inCode;
  logic        wbValid, brDone, flush, outValid, outReady, outIsLoad, outIsBranch;
  logic [9:0]  outPc;
  logic [4:0]  outRd;
  logic [31:0] outRs1, outRs2, outImm, busyVec;
  logic [11:0] outCode;

  issue_stage #(.XLEN(32), .PCLEN(10), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .inPc(inPc),
    .inRd(inRd), .inRs1Idx(inRs1Idx), .inRs2Idx(inRs2Idx), .inRs1(inRs1), .inRs2(inRs2),
    .inImm(inImm), .inCode(inCode), .inIsLoad(inIsLoad), .inIsBranch(inIsBranch),
    .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData), .brDone(brDone), .flush(flush),
    .outValid(outValid), .outReady(outReady), .outPc(outPc), .outRd(outRd),
    .outRs1(outRs1), .outRs2(outRs2), .outImm(outImm), .outCode(outCode),
    .outIsLoad(outIsLoad), .outIsBranch(outIsBranch), .busyVec(busyVec)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  issue_entry_t mq[$];
  logic [31:0]  mbusy = 32'd0;
  logic         mbp   = 1'b0;
  logic         exp_r, exp_v;

  task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Compare outputs against the model for the inputs currently applied
  task automatic apply();
    issue_entry_t h;
    #1;
    exp_r = (mq.size() < DEPTH) && !flush;
    exp_v = 1'b0;
    if (mq.size() > 0) begin
      h = mq[0];
      exp_v = !mbp && !mbusy[h.rs1_idx] && !mbusy[h.rs2_idx] && !mbusy[h.rd] && !flush;
      check_val("head_fields",
        {outPc, outRd, outRs1, outRs2, outImm, outCode, outIsLoad, outIsBranch},
        {h.pc, h.rd, h.rs1, h.rs2, h.imm, h.code, h.is_load, h.is_branch});
    end
    check_val("in_ready", inReady, exp_r);
    check_val("out_valid", outValid, exp_v);
    check_val("busy_vec", busyVec, mbusy);
  endtask

  // Advance one clock and apply the same rules to the model
  task automatic tick();
    issue_entry_t h, e;
    logic wb_en, xfer, enq;
    @(posedge clk);
    wb_en = wbValid && (wbRd != 5'd0);
    if (reset) begin
      mq.delete();
      mbusy = 32'd0;
      mbp   = 1'b0;
    end else begin
      xfer = exp_v && outReady;
      enq  = inValid && exp_r;
      h    = '0;
      if (flush) begin
        mq.delete();
        mbp = 1'b0;
      end else begin
        foreach (mq[i]) begin
          if (wb_en && mq[i].rs1_idx == wbRd) mq[i].rs1 = wbData;
          if (wb_en && mq[i].rs2_idx == wbRd) mq[i].rs2 = wbData;
        end
        if (xfer) h = mq.pop_front();
        if (xfer && h.is_branch) mbp = 1'b1;
        else if (brDone) mbp = 1'b0;
        if (enq) begin
          e.pc = inPc; e.rd = inRd; e.rs1_idx = inRs1Idx; e.rs2_idx = inRs2Idx;
          e.rs1 = (wb_en && inRs1Idx == wbRd) ? wbData : inRs1;
          e.rs2 = (wb_en && inRs2Idx == wbRd) ? wbData : inRs2;
          e.imm = inImm; e.code = inCode; e.is_load = inIsLoad; e.is_branch = inIsBranch;
          mq.push_back(e);
        end
      end
      if (wb_en) mbusy[wbRd] = 1'b0;
      if (xfer && h.rd != 5'd0) mbusy[h.rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inValid = 1'b0; inPc = 10'd0; inRd = 5'd0; inRs1Idx = 5'd0; inRs2Idx = 5'd0;
    inRs1 = 32'd0; inRs2 = 32'd0; inImm = 32'd0; inCode = 12'd0;
    inIsLoad = 1'b0; inIsBranch = 1'b0; wbValid = 1'b0; wbRd = 5'd0; wbData = 32'd0;
    brDone = 1'b0; flush = 1'b0; outReady = 1'b1;
  endtask

  task automatic set_instr(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
    inValid = 1'b1; inRd = rd; inRs1Idx = s1; inRs2Idx = s2;
    inPc = $urandom; inRs1 = $urandom; inRs2 = $urandom; inImm = $urandom;
    inCode = 12'h033; inIsLoad = 1'b0; inIsBranch = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    apply();
    check_val("rst_in_ready", inReady, 1'b1);
    check_val("rst_out_valid", outValid, 1'b0);
    check_val("rst_busy", busyVec, 32'd0);
    tick();
    reset = 1'b0;

    // Read-after-write: producer rd=5, consumer waits for writeback of x5
    set_instr(5'd5, 5'd1, 5'd2); apply(); tick();
    inValid = 1'b0; apply();
    check_val("raw_prod_issue", outValid, 1'b1); tick();
    set_instr(5'd6, 5'd5, 5'd0); apply(); tick();
    inValid = 1'b0; apply();
    check_val("raw_hold", outValid, 1'b0); tick();
    wbValid = 1'b1; wbRd = 5'd5; wbData = 32'h1234; apply(); tick();
    wbValid = 1'b0; outReady = 1'b0; apply();
    check_val("raw_release", outValid, 1'b1);
    check_val("raw_rs1", outRs1, 32'h1234);
    check_val("raw_busy5", busyVec[5], 1'b0);
    tick();

    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      outReady   = ($urandom_range(0, 3) != 0);
      brDone     = ($urandom_range(0, 3) == 0);
      wbValid    = ($urandom_range(0, 1) == 1);
      wbRd       = 5'($urandom_range(0, 7));
      wbData     = $urandom;
      set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      inValid    = ($urandom_range(0, 3) != 0);
      inIsLoad   = ($urandom_range(0, 3) == 0);
      inIsBranch = ($urandom_range(0, 5) == 0);
      inCode     = 12'($urandom);
      apply();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
